// File: rtl/sad_pkg.sv
// sad_pkg: shared definitions for the SAD block accumulator.
//   - default widths for pixel, lane count and SAD result
//   - lane_sum_w(): width of a per-beat lane sum
//   - beat_tag_t: first/last-of-block marker carried through stage 1
//   - sad_state_t: accumulator control states
package sad_pkg;

    localparam int unsigned PIXEL_W_DEF = 8;
    localparam int unsigned LANES_DEF   = 4;
    localparam int unsigned SAD_W_DEF   = 32;

    function automatic int unsigned lane_sum_w(input int unsigned pixel_w,
                                               input int unsigned lanes);
        return pixel_w + $clog2(lanes);
    endfunction

    typedef struct packed {
        logic first;
        logic last;
    } beat_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } sad_state_t;

endpackage

// File: rtl/sad_absdiff_lane.sv
// sad_absdiff_lane: combinational unsigned absolute difference of one lane.
//   a, b  : unsigned pixels
//   diff  : |a - b|
module sad_absdiff_lane #(
    parameter int unsigned PIXEL_W = 8
) (
    input  logic [PIXEL_W-1:0] a,
    input  logic [PIXEL_W-1:0] b,
    output logic [PIXEL_W-1:0] diff
);

    assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_block_accumulator.sv
// sad_block_accumulator: streams current/candidate pixel beats, accumulates
// one SAD per candidate block and tags it with the candidate coordinates.
//   Clk, Rst          : clock, synchronous active-high reset
//   frame_start       : restart candidate scan at (0,0)
//   in_valid/in_ready : pixel beat handshake (cur_pix, ref_pix, lane 0 in LSBs)
//   sad_valid/sad_ready : result handshake
//   sadAdderFinal, cand_row, cand_col, sad_last : result and its candidate
module sad_block_accumulator
    import sad_pkg::*;
#(
    parameter int unsigned PIXEL_W   = PIXEL_W_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned BLOCK_PIX = 16,
    parameter int unsigned SEARCH_W  = 8,
    parameter int unsigned SEARCH_H  = 8,
    parameter int unsigned SAD_W     = SAD_W_DEF,
    localparam int unsigned ROW_W    = (SEARCH_H > 1) ? $clog2(SEARCH_H) : 1,
    localparam int unsigned COL_W    = (SEARCH_W > 1) ? $clog2(SEARCH_W) : 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     frame_start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*PIXEL_W-1:0] cur_pix,
    input  logic [LANES*PIXEL_W-1:0] ref_pix,
    output logic                     sad_valid,
    input  logic                     sad_ready,
    output logic [SAD_W-1:0]         sadAdderFinal,
    output logic [ROW_W-1:0]         cand_row,
    output logic [COL_W-1:0]         cand_col,
    output logic                     sad_last
);

    localparam int unsigned LSUM_W = lane_sum_w(PIXEL_W, LANES);
    localparam int unsigned BEATS  = BLOCK_PIX / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [63:0] SAD_NEED = 64'(BLOCK_PIX) * ((64'd1 << PIXEL_W) - 64'd1);
    localparam logic [63:0] SAD_CAP  = (SAD_W >= 64) ? '1 : ((64'd1 << SAD_W) - 64'd1);

    if (BLOCK_PIX % LANES != 0) begin : g_chk_lanes
        $error("BLOCK_PIX must be a multiple of LANES");
    end
    if (SAD_NEED > SAD_CAP) begin : g_chk_sad_w
        $error("SAD_W too narrow for BLOCK_PIX*(2^PIXEL_W-1)");
    end

    // Stage 1 combinational: per-lane |cur-ref| and lane sum
    logic [PIXEL_W-1:0] diff [LANES];
    logic [LSUM_W-1:0]  lane_sum;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sad_absdiff_lane #(.PIXEL_W(PIXEL_W)) u_lane (
            .a    (cur_pix[g*PIXEL_W +: PIXEL_W]),
            .b    (ref_pix[g*PIXEL_W +: PIXEL_W]),
            .diff (diff[g])
        );
    end

    always_comb begin
        lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + LSUM_W'(diff[i]);
        end
    end

    // Control
    sad_state_t         state, state_d;
    logic               stall, accept, consume, wr;
    logic [BEAT_W-1:0]  beat_cnt, beat_cnt_d, beat_base;
    beat_tag_t          in_tag;
    logic               s1_valid, s1_valid_d;
    logic [LSUM_W-1:0]  s1_sum;
    beat_tag_t          s1_tag;
    logic [SAD_W-1:0]   acc, sum_ext, blk_sum;
    logic [ROW_W-1:0]   row_cnt;
    logic [COL_W-1:0]   col_cnt;

    assign sad_valid = (state == ST_HOLD);
    assign stall     = sad_valid && !sad_ready;
    assign in_ready  = !stall && !Rst;
    assign accept    = in_valid && in_ready;

    // A beat accepted with frame_start is beat 0 of the new scan
    assign beat_base    = frame_start ? '0 : beat_cnt;
    assign in_tag.first = (beat_base == '0);
    assign in_tag.last  = (beat_base == BEAT_W'(BEATS - 1));

    // frame_start throws away whatever stage 1 holds
    assign consume = s1_valid && !stall && !frame_start;
    assign wr      = consume && s1_tag.last;
    assign sum_ext = SAD_W'(s1_sum);
    assign blk_sum = s1_tag.first ? sum_ext : (acc + sum_ext);

    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        s1_valid_d = s1_valid;
        if (frame_start) beat_cnt_d = '0;
        if (accept) beat_cnt_d = in_tag.last ? '0 : (beat_base + BEAT_W'(1));
        if (!stall || frame_start) s1_valid_d = accept;
        // HOLD wins while a result is present; otherwise ACCUM whenever
        // any beat of an unfinished block is counted or in flight
        if (wr || stall)
            state_d = ST_HOLD;
        else if ((beat_cnt_d != '0) || s1_valid_d)
            state_d = ST_ACCUM;
        else
            state_d = ST_IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_tag   <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
            s1_valid <= s1_valid_d;
            if (accept) begin
                s1_sum <= lane_sum;
                s1_tag <= in_tag;
            end
        end
    end

    // Stage 2: accumulator, output register, candidate counters
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc           <= '0;
            sadAdderFinal <= '0;
            cand_row      <= '0;
            cand_col      <= '0;
            sad_last      <= 1'b0;
            row_cnt       <= '0;
            col_cnt       <= '0;
        end else if (frame_start) begin
            acc     <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (consume) begin
            acc <= blk_sum;
            if (wr) begin
                sadAdderFinal <= blk_sum;
                cand_row      <= row_cnt;
                cand_col      <= col_cnt;
                sad_last      <= (row_cnt == ROW_W'(SEARCH_H - 1)) &&
                                 (col_cnt == COL_W'(SEARCH_W - 1));
                if (col_cnt == COL_W'(SEARCH_W - 1)) begin
                    col_cnt <= '0;
                    if (row_cnt == ROW_W'(SEARCH_H - 1))
                        row_cnt <= '0;
                    else
                        row_cnt <= row_cnt + ROW_W'(1);
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_block_accumulator.sv
// tb_sad_block_accumulator: directed stimulus with a scoreboard queue of
// expected results; a monitor pops and compares on every consumed result.
module tb_sad_block_accumulator;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] cur_pix = '0;
    logic [31:0] ref_pix = '0;
    logic        sad_valid;
    logic        sad_ready = 1'b1;
    logic [31:0] sadAdderFinal;
    logic [2:0]  cand_row;
    logic [2:0]  cand_col;
    logic        sad_last;

    sad_block_accumulator #(
        .PIXEL_W(8), .LANES(4), .BLOCK_PIX(16),
        .SEARCH_W(8), .SEARCH_H(8), .SAD_W(32)
    ) dut (
        .Clk(Clk), .Rst(Rst), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready),
        .cur_pix(cur_pix), .ref_pix(ref_pix),
        .sad_valid(sad_valid), .sad_ready(sad_ready),
        .sadAdderFinal(sadAdderFinal), .cand_row(cand_row),
        .cand_col(cand_col), .sad_last(sad_last)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] sad;
        logic [2:0]  row;
        logic [2:0]  col;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mrow = 0;
    int   mcol = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rep(input logic [7:0] v);
        return {4{v}};
    endfunction

    function automatic void push_exp(input logic [31:0] sad);
        exp_t e;
        e.sad  = sad;
        e.row  = mrow[2:0];
        e.col  = mcol[2:0];
        e.last = (mrow == 7) && (mcol == 7);
        sb.push_back(e);
        if (mcol == 7) begin
            mcol = 0;
            mrow = (mrow == 7) ? 0 : mrow + 1;
        end else begin
            mcol = mcol + 1;
        end
    endfunction

    // Monitor: compare every consumed result against the scoreboard head
    always @(negedge Clk) begin
        if (!Rst && sad_valid && sad_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got sad %0d at (%0d,%0d) expected none",
                         sadAdderFinal, cand_row, cand_col);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sad", sadAdderFinal, e.sad);
                check("cand_row", cand_row, e.row);
                check("cand_col", cand_col, e.col);
                check("sad_last", sad_last, e.last);
            end
        end
    end

    // Present one beat and hold it until accepted (bounded)
    task automatic beat(input logic [31:0] c, input logic [31:0] r, input logic fs);
        int  n;
        logic took;
        n = 0;
        cur_pix = c;
        ref_pix = r;
        in_valid = 1'b1;
        frame_start = fs;
        do begin
            @(negedge Clk);
            took = in_ready;
            @(posedge Clk);
            #1;
            n++;
        end while (!took && n < 200);
        in_valid = 1'b0;
        frame_start = 1'b0;
        if (!took) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: got no accept expected accept");
        end
    endtask

    task automatic block(input logic [31:0] c, input logic [31:0] r, input logic [31:0] sad);
        beat(c, r, 1'b0);
        beat(c, r, 1'b0);
        beat(c, r, 1'b0);
        push_exp(sad);
        beat(c, r, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_col;

        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_sad_valid", sad_valid, 0);
        check("rst_sad", sadAdderFinal, 0);
        check("rst_row", cand_row, 0);
        check("rst_col", cand_col, 0);
        check("rst_last", sad_last, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge Clk);
        #1;

        // Max difference block, with latency check
        block(rep(8'd255), rep(8'd0), 32'd4080);
        check("latency_edge_k", sad_valid, 0);
        @(posedge Clk);
        #1;
        check("latency_edge_k1", sad_valid, 1);

        // Mixed lanes: cur {10,20,30,40}, ref {40,30,20,10}
        block({8'd40, 8'd30, 8'd20, 8'd10}, {8'd10, 8'd20, 8'd30, 8'd40}, 32'd320);
        drain();

        // Restart scan, then 65 blocks covering the whole search grid
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        mrow = 0;
        mcol = 0;
        for (int b = 1; b <= 65; b++) begin
            block(rep(8'(b)), rep(8'd0), 32'(16 * b));
        end
        drain();

        // Backpressure: first result held, second block stalls mid-way
        sad_ready = 1'b0;
        a_col = mcol;
        block(rep(8'd2), rep(8'd0), 32'd32);
        fork
            block(rep(8'd7), rep(8'd4), 32'd48);
            begin
                int n;
                n = 0;
                while (!sad_valid && n < 20) begin
                    @(negedge Clk);
                    n++;
                end
                repeat (3) begin
                    @(negedge Clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_valid", sad_valid, 1);
                    check("stall_sad", sadAdderFinal, 32);
                    check("stall_col", cand_col, a_col);
                end
                @(posedge Clk);
                #1;
                sad_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-block
        beat(rep(8'd9), rep(8'd0), 1'b0);
        beat(rep(8'd9), rep(8'd0), 1'b0);
        Rst = 1'b1;
        @(negedge Clk);
        check("mid_rst_in_ready", in_ready, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        mrow = 0;
        mcol = 0;
        block(rep(8'd1), rep(8'd2), 32'd16);
        drain();

        // Advance to (3,5), start a partial block, then frame_start with a beat
        while (!(mrow == 3 && mcol == 5)) begin
            block(rep(8'd1), rep(8'd0), 32'd16);
        end
        beat(rep(8'd9), rep(8'd0), 1'b0);
        beat(rep(8'd9), rep(8'd0), 1'b0);
        mrow = 0;
        mcol = 0;
        beat(rep(8'd5), rep(8'd0), 1'b1);
        beat(rep(8'd1), rep(8'd0), 1'b0);
        beat(rep(8'd1), rep(8'd0), 1'b0);
        push_exp(32'd32);
        beat(rep(8'd1), rep(8'd0), 1'b0);
        drain();

        repeat (4) @(posedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_block_accumulator.md
# sad_block_accumulator

Upstream stage of the motion-estimation SAD path: streams pixel pairs (current block vs. search-window candidate), forms per-pixel absolute differences, and accumulates one 32-bit sum of absolute differences per candidate block. Each completed sum is presented with its candidate coordinates to the minimum-SAD comparator as `sadAdderFinal`. The block also walks the candidate scan order so downstream logic knows which position each SAD belongs to.

## Interface
- `PIXEL_W`, 8: pixel width, unsigned.
- `LANES`, 4: pixel pairs per input beat.
- `BLOCK_PIX`, 16: pixels per block (4x4); must be a multiple of `LANES`.
- `SEARCH_W`, 8: candidate columns per frame.
- `SEARCH_H`, 8: candidate rows per frame.
- `SAD_W`, 32: result width; elaboration error if `BLOCK_PIX*(2^PIXEL_W-1)` exceeds `2^SAD_W-1`.

- `Clk`  in  1  single clock, rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse; restarts the scan at candidate (0,0).
- `in_valid`  in  1  beat present.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `cur_pix`  in  `LANES*PIXEL_W`  current-block pixels, lane 0 in LSBs.
- `ref_pix`  in  `LANES*PIXEL_W`  candidate pixels, same packing.
- `sad_valid`  out  1  result held.
- `sad_ready`  in  1  downstream consumes on `sad_valid && sad_ready`.
- `sadAdderFinal`  out  `SAD_W`  block SAD.
- `cand_row`  out  `clog2(SEARCH_H)`  row of reported candidate.
- `cand_col`  out  `clog2(SEARCH_W)`  column of reported candidate.
- `sad_last`  out  1  high with the result for (`SEARCH_H-1`,`SEARCH_W-1`).

## Operation
- Stage 1 (registered): per lane `|cur-ref|` (PIXEL_W bits), lane sum to width `PIXEL_W+clog2(LANES)`; carries a first/last-of-block tag.
- Stage 2: accumulator; first beat of block loads lane sum, others add. Last beat writes `acc+lane_sum` into output register with current candidate coordinates, sets `sad_valid`.
- Beat counter 0..`BLOCK_PIX/LANES-1`; wraps after last beat.
- Candidate counters advance when a result is written: col increments; at `SEARCH_W-1` wraps to 0 and row increments; at (`SEARCH_H-1`,`SEARCH_W-1`) both wrap to 0 and `sad_last` is set with that result.
- States: IDLE (no partial block), ACCUM (partial block in progress), HOLD (output full, waiting). HOLD->IDLE/ACCUM on consume.
- Stall: `stall = sad_valid && !sad_ready`; whole pipeline freezes; `in_ready = !stall && !Rst`.
- Output register is also loaded in the same cycle it is consumed (back-to-back results allowed).
- `frame_start`: clears beat and candidate counters, discards stage-1 contents and partial accumulation; a pending unconsumed result stays valid. A beat accepted in the same cycle is beat 0 of candidate (0,0).
- No saturation needed; widths guaranteed by parameter check.

## Timing
- Reset values: `in_ready`=0 during reset, 1 the cycle after; `sad_valid`=0, `sadAdderFinal`=0, `cand_row`=0, `cand_col`=0, `sad_last`=0; all counters and accumulator 0.
- Latency: last beat accepted at edge k -> `sad_valid` high after edge k+1 (2 cycles from presentation).
- Throughput: one beat per cycle when unstalled; one result per `BLOCK_PIX/LANES` cycles.
- Outputs stable while `sad_valid && !sad_ready`.
- `Rst` mid-block: partial sum and pending result discarded; next accepted beat is beat 0 of (0,0).
- `Rst` overrides `frame_start`.

## Structure
- Shared package `sad_pkg`: `PIXEL_W`, `SAD_W`, `LANES` defaults, lane-sum width function, beat-tag typedef (first/last).
- Sub-module `sad_absdiff_lane`: one-lane unsigned `|a-b|`, combinational, instantiated `LANES` times.
- Top holds pipeline registers, counters, FSM, output register.

## Test plan
- All `cur_pix`=255, `ref_pix`=0, 4 beats, `sad_ready`=1 -> `sadAdderFinal`=4080, (0,0), `sad_valid` 2 cycles after last beat.
- Lanes cur={10,20,30,40}, ref={40,30,20,10} every beat -> SAD 4*(30+10+10+30)=320.
- 64 consecutive blocks -> coordinates (0,0),(0,1)..(0,7),(1,0)..(7,7); `sad_last` only on 64th; 65th reports (0,0).
- Hold `sad_ready`=0 after first result -> `in_ready` drops, outputs frozen; release -> second result correct, no beat lost.
- `Rst` after 2 beats, then 4 beats of diff 1 -> SAD 16 at (0,0).
- `frame_start` coincident with an accepted beat mid-scan at (3,5) -> next result reported at (0,0) with that beat counted.
